csd_recoder_seq: RTL and testbench

//   Sequential, parametrised binary->CSD recoder (canonical signed digit, no two adjacent nonzero digits).

---
 rtl/csd_pkg.sv | 23 ++
 rtl/csd_digit_cell.sv | 37 +++
 rtl/csd_recoder_seq.sv | 156 +++++++++++++++
 tb/tb_csd_recoder_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csd_pkg.sv
// rtl/csd_pkg.sv - shared FSM state and CSD digit encodings for the sequential recoder

package csd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SCAN = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        D_ZERO = 2'd0,
        D_POS  = 2'd1,
        D_NEG  = 2'd2
    } digit_t;

    function automatic logic is_nonzero(input digit_t d);
        return (d != D_ZERO);
    endfunction

endpackage

// File: rtl/csd_digit_cell.sv
// rtl/csd_digit_cell.sv - one CSD recoding step: (x[i], x[i+1], carry) -> (digit, carry out)

module csd_digit_cell
    import csd_pkg::*;
(
    input  logic   i_xi,
    input  logic   i_xi1,
    input  logic   i_cin,
    output digit_t o_digit,
    output logic   o_cout
);

    logic w_sum_one;
    logic w_sum_two;

    assign w_sum_one = i_xi ^ i_cin;
    assign w_sum_two = i_xi & i_cin;

    // An odd partial sum followed by a 1 becomes -1 with a carry, breaking the run of ones.
    always_comb begin
        o_digit = D_ZERO;
        o_cout  = 1'b0;
        if (w_sum_one) begin
            if (i_xi1) begin
                o_digit = D_NEG;
                o_cout  = 1'b1;
            end else begin
                o_digit = D_POS;
                o_cout  = 1'b0;
            end
        end else if (w_sum_two) begin
            o_digit = D_ZERO;
            o_cout  = 1'b1;
        end
    end

endmodule

// File: rtl/csd_recoder_seq.sv
// rtl/csd_recoder_seq.sv - LSB-first sequential binary->CSD recoder streaming nonzero digits
// CSD_SIGNED_EN: treat x_in as two's complement and use W digits instead of W+1.

module csd_recoder_seq
    import csd_pkg::*;
#(
    parameter int W = 16,
`ifdef CSD_SIGNED_EN
    localparam int ND = W,
`else
    localparam int ND = W + 1,
`endif
    localparam int PW = $clog2(ND),
    localparam int CW = $clog2(ND + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  x_in,
    output logic          busy,
    output logic          dig_valid,
    input  logic          dig_ready,
    output logic [PW-1:0] dig_pos,
    output logic          dig_neg,
    output logic          done,
    output logic [CW-1:0] nz_count,
    output logic [ND-1:0] pos_mask,
    output logic [ND-1:0] neg_mask
);

    localparam logic [PW-1:0] LAST_IDX = PW'(ND - 1);

    state_t        r_state;
    logic [W+1:0]  r_x;
    logic [PW-1:0] r_idx;
    logic          r_carry;
    logic          r_busy;
    logic          r_dig_valid;
    logic [PW-1:0] r_dig_pos;
    logic          r_dig_neg;
    logic          r_done;
    logic [CW-1:0] r_nz_count;
    logic [ND-1:0] r_pos_mask;
    logic [ND-1:0] r_neg_mask;

    logic [W+1:0]  w_x_ext;
    digit_t        w_digit;
    logic          w_cout;
    logic          w_last;

`ifdef CSD_SIGNED_EN
    assign w_x_ext = {{2{x_in[W-1]}}, x_in};
`else
    assign w_x_ext = {2'b00, x_in};
`endif

    assign w_last = (r_idx == LAST_IDX);

    // The operand shifts right as the index advances, so the cell always sees bits 0 and 1.
    csd_digit_cell u_cell (
        .i_xi   (r_x[0]),
        .i_xi1  (r_x[1]),
        .i_cin  (r_carry),
        .o_digit(w_digit),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_busy      <= 1'b0;
            r_dig_valid <= 1'b0;
            r_dig_pos   <= '0;
            r_dig_neg   <= 1'b0;
            r_done      <= 1'b0;
            r_nz_count  <= '0;
            r_pos_mask  <= '0;
            r_neg_mask  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_x        <= w_x_ext;
                    r_idx      <= '0;
                    r_carry    <= 1'b0;
                    r_nz_count <= '0;
                    r_pos_mask <= '0;
                    r_neg_mask <= '0;
                    r_state    <= SCAN;
                end
                SCAN: begin
                    r_carry <= w_cout;
                    if (w_digit == D_POS) begin
                        r_pos_mask[r_idx] <= 1'b1;
                    end
                    if (w_digit == D_NEG) begin
                        r_neg_mask[r_idx] <= 1'b1;
                    end
                    if (is_nonzero(w_digit)) begin
                        r_nz_count  <= r_nz_count + CW'(1);
                        r_dig_pos   <= r_idx;
                        r_dig_neg   <= (w_digit == D_NEG);
                        r_dig_valid <= 1'b1;
                        r_state     <= EMIT;
                    end else if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + PW'(1);
                        r_x   <= r_x >> 1;
                    end
                end
                EMIT: begin
                    if (dig_ready) begin
                        r_dig_valid <= 1'b0;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + PW'(1);
                            r_x     <= r_x >> 1;
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign dig_valid = r_dig_valid;
    assign dig_pos   = r_dig_pos;
    assign dig_neg   = r_dig_neg;
    assign done      = r_done;
    assign nz_count  = r_nz_count;
    assign pos_mask  = r_pos_mask;
    assign neg_mask  = r_neg_mask;

endmodule

// File: tb/tb_csd_recoder_seq.sv
// tb/tb_csd_recoder_seq.sv - self-checking bench for csd_recoder_seq at W=8

module tb_csd_recoder_seq;

    localparam int W = 8;
`ifdef CSD_SIGNED_EN
    localparam int ND = W;
`else
    localparam int ND = W + 1;
`endif
    localparam int PW = $clog2(ND);
    localparam int CW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          dig_ready = 1'b1;
    logic [W-1:0]  x_in = '0;
    logic          busy;
    logic          dig_valid;
    logic [PW-1:0] dig_pos;
    logic          dig_neg;
    logic          done;
    logic [CW-1:0] nz_count;
    logic [ND-1:0] pos_mask;
    logic [ND-1:0] neg_mask;

    csd_recoder_seq #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_in     (x_in),
        .busy     (busy),
        .dig_valid(dig_valid),
        .dig_ready(dig_ready),
        .dig_pos  (dig_pos),
        .dig_neg  (dig_neg),
        .done     (done),
        .nz_count (nz_count),
        .pos_mask (pos_mask),
        .neg_mask (neg_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        int           stall;
        int           nz;
        logic [16:0]  pm;
        logic [16:0]  nm;
        int           lat;
    } vec_t;

    int total = 0;
    int bad = 0;
    int got_pos_q[$];
    int got_neg_q[$];
    int got_lat;
    int got_stalls;
    bit got_timeout;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int xval(input logic [W-1:0] x);
`ifdef CSD_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    // Non-adjacent form by plain arithmetic: odd remainder picks +1 or -1 from v mod 4.
    function automatic void model(input logic [W-1:0] x, output logic [16:0] pm, output logic [16:0] nm);
        int v;
        pm = '0;
        nm = '0;
        v = xval(x);
        for (int i = 0; i < ND; i++) begin
            if ((v & 1) != 0) begin
                if ((v & 3) == 1) begin
                    pm[i] = 1'b1;
                    v = v - 1;
                end else begin
                    nm[i] = 1'b1;
                    v = v + 1;
                end
            end
            v = v / 2;
        end
    endfunction

    task automatic run_conv(input logic [W-1:0] x, input int stall, input bit poke);
        int  n;
        int  pend;
        bit  in_rec;
        bit  fin;
        int  hold_pos;
        int  hold_neg;
        got_pos_q.delete();
        got_neg_q.delete();
        got_stalls = 0;
        got_timeout = 0;
        got_lat = 0;
        pend = 0;
        in_rec = 0;
        fin = 0;
        hold_pos = 0;
        hold_neg = 0;
        @(negedge clk);
        x_in = x;
        start = 1'b1;
        dig_ready = 1'b1;
        n = 1;
        @(negedge clk);
        n = 2;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!fin && n < 400) begin
            if (done) begin
                fin = 1;
            end else begin
                if (n == 3) x_in = ~x;
                start = (poke && n == 5);
                if (dig_valid) begin
                    if (!in_rec) begin
                        in_rec = 1;
                        pend = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                        hold_pos = int'(dig_pos);
                        hold_neg = int'(dig_neg);
                    end else begin
                        check("rec_stable_pos", dig_pos, hold_pos);
                        check("rec_stable_neg", dig_neg, hold_neg);
                    end
                    if (pend > 0) begin
                        dig_ready = 1'b0;
                        pend--;
                        got_stalls++;
                    end else begin
                        dig_ready = 1'b1;
                        got_pos_q.push_back(int'(dig_pos));
                        got_neg_q.push_back(int'(dig_neg));
                        in_rec = 0;
                    end
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        dig_ready = 1'b1;
        got_lat = n;
        if (!fin) begin
            got_timeout = 1;
        end else begin
            check("busy_low_at_done", busy, 0);
            x_in = x;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_one_cycle", done, 0);
            check("start_in_done_ignored", busy, 0);
            @(negedge clk);
        end
    endtask

    task automatic verify(input string tag, input logic [16:0] pm, input logic [16:0] nm,
                          input int nz, input int lat);
        int k;
        logic [16:0] pm_nd;
        logic [16:0] nm_nd;
        pm_nd = pm & ((17'd1 << ND) - 17'd1);
        nm_nd = nm & ((17'd1 << ND) - 17'd1);
        check({tag, "_timeout"}, got_timeout, 0);
        check({tag, "_nz_count"}, nz_count, nz);
        check({tag, "_pos_mask"}, pos_mask, pm_nd);
        check({tag, "_neg_mask"}, neg_mask, nm_nd);
        check({tag, "_n_records"}, got_pos_q.size(), $countones(pm_nd | nm_nd));
        check({tag, "_latency"}, got_lat, lat);
        k = 0;
        for (int i = 0; i < ND; i++) begin
            if ((pm_nd[i] | nm_nd[i]) && k < got_pos_q.size()) begin
                check({tag, "_rec_pos"}, got_pos_q[k], i);
                check({tag, "_rec_neg"}, got_neg_q[k], int'(nm_nd[i]));
                k++;
            end
        end
    endtask

    task automatic check_invariants(input logic [W-1:0] x);
        logic [ND-1:0] nzm;
        longint sum;
        nzm = pos_mask | neg_mask;
        sum = 0;
        for (int i = 0; i < ND; i++) begin
            if (pos_mask[i]) sum = sum + (longint'(1) << i);
            if (neg_mask[i]) sum = sum - (longint'(1) << i);
        end
        check("inv_disjoint", pos_mask & neg_mask, 0);
        check("inv_nonadjacent", nzm & (nzm >> 1), 0);
        check("inv_value", sum, xval(x));
    endtask

    task automatic add_vec(inout vec_t q[$], input logic [W-1:0] x, input int stall, input int nz,
                           input logic [16:0] pm, input logic [16:0] nm, input int lat);
        vec_t v;
        v.x = x;
        v.stall = stall;
        v.nz = nz;
        v.pm = pm;
        v.nm = nm;
        v.lat = lat;
        q.push_back(v);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [16:0] pm;
        logic [16:0] nm;
        logic [W-1:0] rx;
        int          k;
        int          cnt;
        int          nz;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dig_valid", dig_valid, 0);
        check("rst_dig_pos", dig_pos, 0);
        check("rst_dig_neg", dig_neg, 0);
        check("rst_done", done, 0);
        check("rst_nz_count", nz_count, 0);
        check("rst_pos_mask", pos_mask, 0);
        check("rst_neg_mask", neg_mask, 0);
        reset = 1'b0;

`ifdef CSD_SIGNED_EN
        add_vec(tbl, 8'h80, 0, 1, 17'h000, 17'h080, 12);
        add_vec(tbl, 8'h7F, 0, 2, 17'h080, 17'h001, 13);
        add_vec(tbl, 8'h00, 0, 0, 17'h000, 17'h000, 11);
        add_vec(tbl, 8'hFF, 0, 1, 17'h000, 17'h001, 12);
        add_vec(tbl, 8'h07, 0, 2, 17'h008, 17'h001, 13);
        add_vec(tbl, 8'h55, 3, 4, 17'h055, 17'h000, 27);
`else
        add_vec(tbl, 8'h07, 0, 2, 17'h008, 17'h001, 14);
        add_vec(tbl, 8'hFF, 0, 2, 17'h100, 17'h001, 14);
        add_vec(tbl, 8'h00, 0, 0, 17'h000, 17'h000, 12);
        add_vec(tbl, 8'h01, 0, 1, 17'h001, 17'h000, 13);
        add_vec(tbl, 8'h55, 3, 4, 17'h055, 17'h000, 28);
        add_vec(tbl, 8'hAA, 1, 4, 17'h0AA, 17'h000, 20);
`endif
        foreach (tbl[t]) begin
            run_conv(tbl[t].x, tbl[t].stall, 1'b0);
            verify("vec", tbl[t].pm, tbl[t].nm, tbl[t].nz, tbl[t].lat);
        end

        run_conv(8'h3B, 0, 1'b1);
        model(8'h3B, pm, nm);
        nz = $countones(pm | nm);
        verify("poke", pm, nm, nz, 3 + ND + nz);

        @(negedge clk);
        x_in = 8'h07;
        start = 1'b1;
        dig_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!dig_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("abort_emit_reached", dig_valid, 1);
        check("abort_emit_neg", dig_neg, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dig_valid", dig_valid, 0);
        check("abort_dig_pos", dig_pos, 0);
        check("abort_dig_neg", dig_neg, 0);
        check("abort_done", done, 0);
        check("abort_nz_count", nz_count, 0);
        check("abort_pos_mask", pos_mask, 0);
        check("abort_neg_mask", neg_mask, 0);
        @(negedge clk);
        reset = 1'b0;
        dig_ready = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || dig_valid || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);

        for (int r = 0; r < 40; r++) begin
            rx = W'($urandom);
            run_conv(rx, -1, ($urandom_range(0, 3) == 0));
            model(rx, pm, nm);
            nz = $countones(pm | nm);
            verify("rand", pm, nm, nz, 3 + ND + nz + got_stalls);
            check_invariants(rx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
